// File: rtl/sev_seg_capture.sv
// sev_seg_capture: reads the multiplexed active-low seven-segment/anode lines back into a 16-bit hex frame.
// Optional macro SEVSEG_DP_CAPTURE_EN: also captures each digit's decimal point into decimal_points.
module sev_seg_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  segments,
   input  logic [3:0]  anodes,
   output logic [15:0] value,
   output logic [3:0]  digit_err,
   output logic        frame_done,
   output logic        sel_error,
   output logic [3:0]  decimal_points
);

   localparam logic [15:0] CNT_SAT     = 16'(STABLE_CYCLES);
   localparam logic [15:0] CNT_CAPTURE = 16'(STABLE_CYCLES - 2);

   typedef enum logic [1:0] {SEL_ACTIVE, SEL_BLANK, SEL_ILLEGAL} sel_t;

   logic [7:0]  s_seg, p_seg;
   logic [3:0]  s_an, p_an;
   logic [15:0] cnt;
   logic [3:0]  seen;
   logic [15:0] sh_val, sh_val_next;
   logic [3:0]  sh_err, sh_err_next;
   logic [3:0]  dec_nib;
   logic        dec_err;
   logic [1:0]  digit;
   logic [3:0]  digit_mask;
   sel_t        s_sel, p_sel;
   logic        changed, capture, frame_complete;

   function automatic sel_t classify(input logic [3:0] an);
      sel_t c;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: c = SEL_ACTIVE;
         4'b1111:                            c = SEL_BLANK;
         default:                            c = SEL_ILLEGAL;
      endcase
      return c;
   endfunction

   always_comb begin
      dec_nib = 4'h0;
      dec_err = 1'b0;
      case (s_seg[7:1])
         7'b0000001: dec_nib = 4'h0;
         7'b1001111: dec_nib = 4'h1;
         7'b0010010: dec_nib = 4'h2;
         7'b0000110: dec_nib = 4'h3;
         7'b1001100: dec_nib = 4'h4;
         7'b0100100: dec_nib = 4'h5;
         7'b0100000: dec_nib = 4'h6;
         7'b0001111: dec_nib = 4'h7;
         7'b0000000: dec_nib = 4'h8;
         7'b0000100: dec_nib = 4'h9;
         7'b0001000: dec_nib = 4'hA;
         7'b1100000: dec_nib = 4'hB;
         7'b0110001: dec_nib = 4'hC;
         7'b1000010: dec_nib = 4'hD;
         7'b0110000: dec_nib = 4'hE;
         7'b0111000: dec_nib = 4'hF;
         default:    dec_err = 1'b1;
      endcase
   end

   always_comb begin
      case (s_an)
         4'b1101: digit = 2'd1;
         4'b1011: digit = 2'd2;
         4'b0111: digit = 2'd3;
         default: digit = 2'd0;
      endcase
   end

   assign digit_mask     = 4'b0001 << digit;
   assign s_sel          = classify(s_an);
   assign p_sel          = classify(p_an);
   assign changed        = (s_seg != p_seg) || (s_an != p_an);
   assign capture        = (s_sel == SEL_ACTIVE) && !changed && (cnt == CNT_CAPTURE);
   assign frame_complete = capture && ((seen | digit_mask) == 4'b1111);

   // Shadows with the current capture merged in, so a completing frame can load in one edge
   always_comb begin
      sh_val_next = sh_val;
      sh_err_next = sh_err;
      sh_val_next[{digit, 2'b00} +: 4] = dec_nib;
      sh_err_next[digit] = dec_err;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s_seg      <= 8'h00;
         s_an       <= 4'h0;
         p_seg      <= 8'h00;
         p_an       <= 4'h0;
         cnt        <= 16'd0;
         seen       <= 4'b0000;
         sh_val     <= 16'h0000;
         sh_err     <= 4'b0000;
         value      <= 16'h0000;
         digit_err  <= 4'b0000;
         frame_done <= 1'b0;
         sel_error  <= 1'b0;
      end else begin
         s_seg      <= segments;
         s_an       <= anodes;
         p_seg      <= s_seg;
         p_an       <= s_an;
         frame_done <= 1'b0;
         sel_error  <= (s_sel == SEL_ILLEGAL) && (p_sel != SEL_ILLEGAL);
         if (changed || s_sel != SEL_ACTIVE)
            cnt <= 16'd0;
         else if (cnt != CNT_SAT)
            cnt <= cnt + 16'd1;
         if (capture) begin
            sh_val <= sh_val_next;
            sh_err <= sh_err_next;
            if (frame_complete) begin
               value      <= sh_val_next;
               digit_err  <= sh_err_next;
               frame_done <= 1'b1;
               seen       <= 4'b0000;
            end else begin
               seen <= seen | digit_mask;
            end
         end
      end
   end

`ifdef SEVSEG_DP_CAPTURE_EN
   logic [3:0] sh_dp, sh_dp_next;

   // dp is reported as 1 when lit; it never affects glyph validity
   always_comb begin
      sh_dp_next = sh_dp;
      sh_dp_next[digit] = ~s_seg[0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sh_dp          <= 4'b0000;
         decimal_points <= 4'b0000;
      end else if (capture) begin
         sh_dp <= sh_dp_next;
         if (frame_complete)
            decimal_points <= sh_dp_next;
      end
   end
`else
   assign decimal_points = 4'b0000;
`endif

endmodule

// File: tb/tb_sev_seg_capture.sv
// tb_sev_seg_capture: drives display scan patterns into sev_seg_capture and compares published
// frames and select-error pulses against a run-length reference model of the display readback.
module tb_sev_seg_capture;

   localparam int SC = 4;
   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   typedef struct packed {
      logic [31:0] at;
      logic [15:0] val;
      logic [3:0]  err;
      logic [3:0]  dp;
   } frame_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  segments;
   logic [3:0]  anodes;
   logic [15:0] value;
   logic [3:0]  digit_err;
   logic        frame_done;
   logic        sel_error;
   logic [3:0]  decimal_points;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   frame_t exp_frames[$], obs_frames[$];
   int     exp_sel[$], obs_sel[$];

   logic [3:0]  m_nib [4];
   logic [3:0]  m_err, m_dp, m_seen;
   logic [15:0] m_value;
   logic [7:0]  cur_seg;
   logic [3:0]  cur_an;
   int          cur_len;
   bit          cur_valid;
   bit          cur_ill;

   sev_seg_capture #(.STABLE_CYCLES(SC)) dut (
      .clk(clk), .reset_n(reset_n), .segments(segments), .anodes(anodes),
      .value(value), .digit_err(digit_err), .frame_done(frame_done),
      .sel_error(sel_error), .decimal_points(decimal_points));

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Record every published frame and select-error pulse with the edge count it followed
   always @(negedge clk) begin
      if (frame_done) obs_frames.push_back('{32'(cyc), value, digit_err, decimal_points});
      if (sel_error)  obs_sel.push_back(cyc);
   end

   function automatic logic [7:0] seg_of(input int n, input bit dp_lit);
      return {GLYPH[n], ~dp_lit};
   endfunction

   function automatic logic [3:0] dig_an(input int n);
      logic [3:0] a = 4'b1111;
      a[n] = 1'b0;
      return a;
   endfunction

   task automatic model_capture(input int d, input logic [7:0] seg, input int at);
      int g = -1;
      for (int i = 0; i < 16; i++) if (GLYPH[i] == seg[7:1]) g = i;
      m_nib[d] = (g < 0) ? 4'h0 : g[3:0];
      m_err[d] = (g < 0);
`ifdef SEVSEG_DP_CAPTURE_EN
      m_dp[d] = ~seg[0];
`else
      m_dp[d] = 1'b0;
`endif
      m_seen[d] = 1'b1;
      if (m_seen == 4'hF) begin
         m_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
         exp_frames.push_back('{32'(at), m_value, m_err, m_dp});
         m_seen = 4'h0;
      end
   endtask

   // One display cycle: a run of identical samples is captured once it reaches SC samples
   task automatic drive(input logic [7:0] seg, input logic [3:0] an);
      segments = seg;
      anodes   = an;
      if (!cur_valid || seg != cur_seg || an != cur_an) begin
         bit ill = ($countones(~an) >= 2);
         if (ill && !cur_ill) exp_sel.push_back(cyc + 2);
         cur_ill   = ill;
         cur_seg   = seg;
         cur_an    = an;
         cur_valid = 1'b1;
         cur_len   = 1;
      end else begin
         cur_len++;
      end
      if (cur_len == SC && $countones(~an) == 1) begin
         int d = 0;
         for (int i = 0; i < 4; i++) if (!an[i]) d = i;
         model_capture(d, seg, cyc + 2);
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [7:0] seg, input logic [3:0] an, input int len);
      repeat (len) drive(seg, an);
   endtask

   task automatic do_reset(input int n);
      reset_n  = 1'b0;
      segments = 8'hFF;
      anodes   = 4'hF;
      repeat (n) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
      m_err = 4'h0; m_dp = 4'h0; m_seen = 4'h0; m_value = 16'h0;
      cur_valid = 1'b0;
      cur_ill   = 1'b1;
   endtask

   task automatic clear_queues();
      exp_frames.delete(); obs_frames.delete();
      exp_sel.delete();    obs_sel.delete();
   endtask

   task automatic test_reset();
      do_reset(3);
      run(8'hFF, 4'hF, 2);
      total++; if (value !== 16'h0000) begin bad++; $display("[TB] FAIL reset_value: got %h want %h", value, 16'h0000); end
      total++; if (digit_err !== 4'b0000) begin bad++; $display("[TB] FAIL reset_err: got %b want %b", digit_err, 4'b0000); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", frame_done); end
      total++; if (sel_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_sel: got %b want 0", sel_error); end
      total++; if (decimal_points !== 4'b0000) begin bad++; $display("[TB] FAIL reset_dp: got %b want %b", decimal_points, 4'b0000); end
   endtask

   task automatic test_short_windows();
      clear_queues();
      for (int n = 0; n < 4; n++) run(seg_of(n + 1, 1'b0), dig_an(n), SC - 1);
      for (int n = 0; n < 4; n++) run(seg_of(n + 5, 1'b0), dig_an(n), SC - 1);
      run(8'hFF, 4'hF, SC + 2);
      total++; if (obs_frames.size() != 0) begin bad++; $display("[TB] FAIL short_frames: got %0d want 0", obs_frames.size()); end
      total++; if (value !== 16'h0000) begin bad++; $display("[TB] FAIL short_value: got %h want %h", value, 16'h0000); end
   endtask

   task automatic test_basic_scan();
      clear_queues();
      for (int n = 0; n < 4; n++) run(seg_of(n + 1, 1'b0), dig_an(n), 6);
      run(8'hFF, 4'hF, SC + 2);
      total++; if (obs_frames.size() != 1) begin bad++; $display("[TB] FAIL basic_frames: got %0d want 1", obs_frames.size()); end
      total++; if (value !== 16'h4321) begin bad++; $display("[TB] FAIL basic_value: got %h want %h", value, 16'h4321); end
      total++; if (digit_err !== 4'b0000) begin bad++; $display("[TB] FAIL basic_err: got %b want %b", digit_err, 4'b0000); end
      for (int i = 0; i < obs_frames.size() && i < exp_frames.size(); i++) begin
         total++;
         if (obs_frames[i] !== exp_frames[i]) begin
            bad++;
            $display("[TB] FAIL basic_frame[%0d]: got %h want %h", i, obs_frames[i], exp_frames[i]);
         end
      end
   endtask

   task automatic test_bad_glyph();
      clear_queues();
      run(seg_of(10, 1'b0), dig_an(0), 6);
      run(seg_of(11, 1'b0), dig_an(1), 6);
      run(8'hC5, dig_an(2), 6);
      run(seg_of(15, 1'b0), dig_an(3), 6);
      run(8'hFF, 4'hF, SC + 2);
      total++; if (obs_frames.size() != 1) begin bad++; $display("[TB] FAIL glyph_frames: got %0d want 1", obs_frames.size()); end
      total++; if (value !== 16'hF0BA) begin bad++; $display("[TB] FAIL glyph_value: got %h want %h", value, 16'hF0BA); end
      total++; if (digit_err !== 4'b0100) begin bad++; $display("[TB] FAIL glyph_err: got %b want %b", digit_err, 4'b0100); end
   endtask

   task automatic test_sel_error();
      clear_queues();
      run(seg_of(5, 1'b0), dig_an(0), 6);
      run(seg_of(6, 1'b0), dig_an(1), 6);
      run(8'h9F, 4'b1100, 2);
      run(seg_of(7, 1'b0), dig_an(2), 6);
      run(seg_of(9, 1'b0), dig_an(3), 6);
      run(8'hFF, 4'hF, SC + 2);
      total++; if (obs_sel.size() != 1) begin bad++; $display("[TB] FAIL sel_pulses: got %0d want 1", obs_sel.size()); end
      if (obs_sel.size() > 0 && exp_sel.size() > 0) begin
         total++; if (obs_sel[0] != exp_sel[0]) begin bad++; $display("[TB] FAIL sel_timing: got %0d want %0d", obs_sel[0], exp_sel[0]); end
      end
      total++; if (value !== 16'h9765) begin bad++; $display("[TB] FAIL sel_value: got %h want %h", value, 16'h9765); end
      for (int i = 0; i < obs_frames.size() && i < exp_frames.size(); i++) begin
         total++;
         if (obs_frames[i] !== exp_frames[i]) begin
            bad++;
            $display("[TB] FAIL sel_frame[%0d]: got %h want %h", i, obs_frames[i], exp_frames[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_queues();
      for (int n = 0; n < 3; n++) run(seg_of(n + 1, 1'b0), dig_an(n), 6);
      run(8'hFF, 4'hF, 1);
      do_reset(1);
      run(8'hFF, 4'hF, 2);
      total++; if (value !== 16'h0000) begin bad++; $display("[TB] FAIL midreset_value: got %h want %h", value, 16'h0000); end
      for (int n = 0; n < 3; n++) run(seg_of(8, 1'b0), dig_an(n), 6);
      total++; if (obs_frames.size() != 0) begin bad++; $display("[TB] FAIL midreset_early: got %0d frames want 0", obs_frames.size()); end
      run(seg_of(8, 1'b0), dig_an(3), 6);
      run(8'hFF, 4'hF, SC + 2);
      total++; if (obs_frames.size() != 1) begin bad++; $display("[TB] FAIL midreset_frames: got %0d want 1", obs_frames.size()); end
      total++; if (value !== 16'h8888) begin bad++; $display("[TB] FAIL midreset_value2: got %h want %h", value, 16'h8888); end
      for (int i = 0; i < obs_frames.size() && i < exp_frames.size(); i++) begin
         total++;
         if (obs_frames[i] !== exp_frames[i]) begin
            bad++;
            $display("[TB] FAIL midreset_frame[%0d]: got %h want %h", i, obs_frames[i], exp_frames[i]);
         end
      end
   endtask

   task automatic test_dp();
      logic [3:0] want_dp;
`ifdef SEVSEG_DP_CAPTURE_EN
      want_dp = 4'b1111;
`else
      want_dp = 4'b0000;
`endif
      clear_queues();
      for (int n = 0; n < 4; n++) run(8'h02, dig_an(n), 6);
      run(8'hFF, 4'hF, SC + 2);
      total++; if (value !== 16'h0000) begin bad++; $display("[TB] FAIL dp_value: got %h want %h", value, 16'h0000); end
      total++; if (digit_err !== 4'b0000) begin bad++; $display("[TB] FAIL dp_err: got %b want %b", digit_err, 4'b0000); end
      total++; if (decimal_points !== want_dp) begin bad++; $display("[TB] FAIL dp_points: got %b want %b", decimal_points, want_dp); end
      total++; if (obs_frames.size() != 1) begin bad++; $display("[TB] FAIL dp_frames: got %0d want 1", obs_frames.size()); end
   endtask

   task automatic test_random();
      clear_queues();
      for (int r = 0; r < 150; r++) begin
         logic [7:0] seg;
         logic [3:0] an;
         int         pick = $urandom_range(0, 9);
         if (pick <= 6)      an = dig_an($urandom_range(0, 3));
         else if (pick == 7) an = 4'hF;
         else begin
            an = 4'(($urandom % 16));
            while ($countones(~an) < 2) an = 4'(($urandom % 16));
         end
         if ($urandom_range(0, 3) != 0) seg = seg_of($urandom_range(0, 15), 1'($urandom % 2));
         else                           seg = 8'($urandom);
         run(seg, an, $urandom_range(1, 7));
      end
      run(8'hFF, 4'hF, SC + 2);
      total++; if (obs_frames.size() != exp_frames.size()) begin bad++; $display("[TB] FAIL rand_frames: got %0d want %0d", obs_frames.size(), exp_frames.size()); end
      for (int i = 0; i < obs_frames.size() && i < exp_frames.size(); i++) begin
         total++;
         if (obs_frames[i] !== exp_frames[i]) begin
            bad++;
            $display("[TB] FAIL rand_frame[%0d]: got %h want %h", i, obs_frames[i], exp_frames[i]);
         end
      end
      total++; if (obs_sel.size() != exp_sel.size()) begin bad++; $display("[TB] FAIL rand_sel: got %0d want %0d", obs_sel.size(), exp_sel.size()); end
      for (int i = 0; i < obs_sel.size() && i < exp_sel.size(); i++) begin
         total++;
         if (obs_sel[i] != exp_sel[i]) begin
            bad++;
            $display("[TB] FAIL rand_sel[%0d]: got %0d want %0d", i, obs_sel[i], exp_sel[i]);
         end
      end
      total++; if (value !== m_value) begin bad++; $display("[TB] FAIL rand_value: got %h want %h", value, m_value); end
   endtask

   initial begin
      reset_n  = 1'b0;
      segments = 8'hFF;
      anodes   = 4'hF;
      cur_ill  = 1'b1;
      @(negedge clk);
      test_reset();
      test_short_windows();
      test_basic_scan();
      test_bad_glyph();
      test_sel_error();
      test_reset_mid_frame();
      test_dp();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sev_seg_capture.md
# sev_seg_capture

- Seven-segment display decoder: the inverse of the display encoder.
- Monitors the multiplexed, active-low segment and anode lines driven to the 4-digit display and recovers the displayed 16-bit hex value.
- Each digit is qualified by a stability counter, then decoded. A frame is published once all four digits have been captured.
- Sits beside the display driver as an on-chip self-check and readback path.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured; legal range 2..65535.
- Clk  input  1  system clock; all logic on rising edge.
- Reset_n  input  1  reset, synchronous, active-low.
- Segments  input  8  active-low segment lines; bit7=a … bit1=g, bit0=dp.
- Anodes  input  4  active-low digit selects; Anodes[n] low selects digit n.
- Value  output  16  last complete frame; digit n in Value[4n+3:4n].
- DigitErr  output  4  per-digit flag: pattern in last frame was not a legal hex glyph.
- FrameDone  output  1  one-cycle pulse when Value/DigitErr update.
- SelError  output  1  one-cycle pulse on an illegal anode pattern.
- DecimalPoints  output  4  per-digit dp state of last frame (see Configuration).

## Operation
- Input stage: Segments and Anodes registered every cycle into sample register S. No other logic sees the raw inputs.
- Select classification of S.Anodes:
  - exactly one bit low: active digit.
  - 4'b1111: blanking.
  - two or more bits low: illegal.
- Stability counter Cnt:
  - cleared when S differs from the previous S, on blanking, or on illegal select;
  - otherwise increments, saturating at STABLE_CYCLES.
- Capture: on the cycle Cnt transitions to STABLE_CYCLES-1 with an active digit, that digit's shadow nibble, error bit and dp bit are written, and its seen bit is set. Exactly one capture per stable window; no re-capture until S changes.
- Decode of Segments[7:1] (a..g, 0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, B=1100000
  - C=0110001, D=1000010, E=0110000, F=0111000
  - any other pattern: nibble 0, error bit 1.
- Frame: when the seen bits, including the current capture, equal 4'b1111:
  - Value, DigitErr and DecimalPoints are loaded from the shadows on that same edge;
  - FrameDone asserts for the following cycle;
  - seen bits clear.
- Same digit captured twice before the frame completes: the later capture overwrites the shadow.
- Illegal select: SelError pulses on each cycle S newly enters an illegal state. No capture occurs; the partial frame is retained.

## Timing
- Reset values: Value=16'h0000, DigitErr=4'b0000, FrameDone=0, SelError=0, DecimalPoints=4'b0000; shadows, seen bits, Cnt and S all cleared.
- Reset mid-frame discards the partial frame and all seen bits.
- Capture latency: inputs stable from edge t are captured at edge t+STABLE_CYCLES (1 input-register cycle plus STABLE_CYCLES-1 counting).
- FrameDone is high in the cycle after the fourth-digit capture edge; Value is valid in that same cycle.
- SelError is high in the cycle after S first holds an illegal select.
- Windows shorter than STABLE_CYCLES samples (ghosting during anode switching) are never captured.

## Configuration
- SEVSEG_DP_CAPTURE_EN defined:
  - Segments[0] is captured per digit (DecimalPoints[n] = ~Segments[0], i.e. 1 when lit);
  - dp state does not affect glyph validity.
- Not defined:
  - Segments[0] is ignored for capture;
  - DecimalPoints is tied to 4'b0000 and no dp registers exist.
- In both cases a change in Segments[0] restarts the stability counter.

## Test plan
- STABLE_CYCLES=4; scan digits 0..3 with glyphs 1, 2, 3, 4 (Segments 8'h9F, 8'h25, 8'h0D, 8'h99), each held 6 cycles -> single FrameDone pulse, Value=16'h4321, DigitErr=0.
- Digit 2 driven Segments=8'hC5 in a full scan of A, B, ?, F -> Value=16'hF0BA, DigitErr=4'b0100.
- Each digit held only 3 cycles with STABLE_CYCLES=4 -> no capture, no FrameDone, Value stays 16'h0000.
- Anodes=4'b1100 for 2 cycles mid-scan -> one SelError pulse. Remaining digits still complete the frame with correct Value.
- Reset_n low for 1 cycle after 3 of 4 digits captured, then a full scan of 8,8,8,8 -> FrameDone only after all four new captures, Value=16'h8888.
- Macro defined, all digits Segments=8'h02 (glyph 0, dp lit) -> Value=16'h0000, DigitErr=0, DecimalPoints=4'b1111. Without the macro -> DecimalPoints=4'b0000.
